// File: rtl/pwmc_pkg.sv
// -----------------------------------------------------------------------------
// pwmc_pkg
// Shared definitions for the PWM LED controller fault path: channel/fault
// widths, the error-read command code, the scan FSM state type, the per-channel
// fault vector and the helper that packs a fault vector into the two error
// frame bytes returned to the command receiver.
//
// Fault vector layout (15 bits, MSB first):
//   [14:9] short[5:0]   [8:3] open[5:0]   [2] overheat   [1] overvoltage
//   [0] undervoltage
// -----------------------------------------------------------------------------
package pwmc_pkg;

    localparam int          FAULT_W    = 15;
    localparam int          NUM_CH     = 4;
    localparam logic [3:0]  ERR_RD_CMD = 4'b1110;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SAMPLE = 2'd1,
        S_NEXT   = 2'd2
    } scan_state_t;

    typedef logic [FAULT_W-1:0] fault_vec_t;

    // Returns {frame0, frame1}.
    // frame0 = {short[5:0], open[5:4]}
    // frame1 = {open[3:0], 1'b1, overheat, overvoltage, undervoltage}
    function automatic logic [15:0] build_frames(input fault_vec_t v);
        return {v[14:7], v[6:3], 1'b1, v[2:0]};
    endfunction

endpackage

// File: rtl/fault_debounce.sv
// -----------------------------------------------------------------------------
// fault_debounce
// One channel's worth of fault debouncing: 15 saturating counters plus the
// sticky bits they set.
//
// Optional feature macro: FAULT_IRQ_EN (adds the rise output).
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sample_en  one-cycle strobe: this channel is being sampled now
//   raw        15-bit raw fault vector of the channel
//   clr        clear-on-read of all sticky bits (a simultaneous set wins)
//   sticky     15-bit sticky fault bits
//   rise       (FAULT_IRQ_EN only) bits going 0 -> 1 at the coming edge
// -----------------------------------------------------------------------------
module fault_debounce
    import pwmc_pkg::*;
#(
    parameter int DEB_N = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  fault_vec_t raw,
    input  logic       clr,
    output fault_vec_t sticky
`ifdef FAULT_IRQ_EN
    ,
    output fault_vec_t rise
`endif
);

    localparam logic [2:0] DEB_MAX = 3'(DEB_N);

    fault_vec_t set_vec;
    fault_vec_t sticky_reg;

    generate
        for (genvar gi = 0; gi < FAULT_W; gi++) begin : g_bit
            logic [2:0] cnt_reg;
            logic [2:0] cnt_inc;

            // Saturate at DEB_N so a persisting fault keeps re-asserting the
            // set condition on every sample (re-latch after clear-on-read).
            assign cnt_inc     = (cnt_reg == DEB_MAX) ? cnt_reg : cnt_reg + 3'd1;
            assign set_vec[gi] = sample_en & raw[gi] & (cnt_inc == DEB_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (sample_en) begin
                    cnt_reg <= raw[gi] ? cnt_inc : 3'd0;
                end
            end
        end
    endgenerate

    // Clear first, then OR in new sets: a latch in the clearing cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= (clr ? '0 : sticky_reg) | set_vec;
        end
    end

    assign sticky = sticky_reg;

`ifdef FAULT_IRQ_EN
    assign rise = set_vec & ~sticky_reg;
`endif

endmodule

// File: rtl/fault_scan_scheduler.sv
// -----------------------------------------------------------------------------
// fault_scan_scheduler
// Time-multiplexed fault monitor for the 2x2 LED driver tile. Samples the four
// channels round-robin (one sample every SCAN_DIV+2 cycles), debounces each
// fault bit into sticky registers and serves error-frame reads with a fixed
// one-cycle request/ack handshake and clear-on-read.
//
// Optional feature macro: FAULT_IRQ_EN (adds irq_mask_i / irq_o).
//
// Ports:
//   sys_clk         system clock
//   sys_resetb      asynchronous active-low reset
//   short_i[24]     channel c short flags at [6c+5:6c]
//   open_i[24]      channel c open flags at [6c+5:6c]
//   overheat_i[4]   per-channel overheat
//   overvoltage_i[4], undervoltage_i[4]  per-channel supply faults
//   rd_req, rd_id   single-cycle read strobe and channel ID
//   rd_ack, rd_hit  one-cycle acknowledge; hit = ID matched a channel
//   frame0_o/1_o    error frame bytes (8'hFF on a miss), held between acks
//   error_flag_o    registered OR of all sticky bits
//   scan_ch_o       channel sampled most recently
//   irq_mask_i[4]   (FAULT_IRQ_EN) per-channel irq suppression
//   irq_o           (FAULT_IRQ_EN) pulse on any unmasked sticky 0 -> 1
// -----------------------------------------------------------------------------
module fault_scan_scheduler
    import pwmc_pkg::*;
#(
    parameter logic [4:0] ROW      = 5'd0,
    parameter logic [2:0] COLUMN   = 3'd1,
    parameter int         SCAN_DIV = 16,
    parameter int         DEB_N    = 3
) (
    input  logic        sys_clk,
    input  logic        sys_resetb,
    input  logic [23:0] short_i,
    input  logic [23:0] open_i,
    input  logic [3:0]  overheat_i,
    input  logic [3:0]  overvoltage_i,
    input  logic [3:0]  undervoltage_i,
    input  logic        rd_req,
    input  logic [7:0]  rd_id,
    output logic        rd_ack,
    output logic        rd_hit,
    output logic [7:0]  frame0_o,
    output logic [7:0]  frame1_o,
    output logic        error_flag_o,
    output logic [1:0]  scan_ch_o
`ifdef FAULT_IRQ_EN
    ,
    input  logic [3:0]  irq_mask_i,
    output logic        irq_o
`endif
);

    localparam int             PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------ scan
    scan_state_t      state_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [1:0]       ch_idx_reg;
    logic [1:0]       scan_ch_reg;

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            state_reg   <= S_WAIT;
            pre_reg     <= '0;
            ch_idx_reg  <= 2'd0;
            scan_ch_reg <= 2'd0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (pre_reg == PRE_MAX) begin
                        pre_reg   <= '0;
                        state_reg <= S_SAMPLE;
                    end else begin
                        pre_reg <= pre_reg + 1'b1;
                    end
                end
                S_SAMPLE: state_reg <= S_NEXT;
                S_NEXT: begin
                    scan_ch_reg <= ch_idx_reg;
                    ch_idx_reg  <= ch_idx_reg + 2'd1;
                    state_reg   <= S_WAIT;
                end
                default: state_reg <= S_WAIT;
            endcase
        end
    end

    // ------------------------------------------------------ per-channel path
    fault_vec_t        raw_all    [NUM_CH];
    fault_vec_t        sticky_all [NUM_CH];
    logic [NUM_CH-1:0] sample_en;
    logic [NUM_CH-1:0] hit_vec;
`ifdef FAULT_IRQ_EN
    fault_vec_t        rise_all   [NUM_CH];
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Channel ID = {ROW + c[1], COLUMN + c[0]}.
            localparam logic [7:0] CH_ID = {ROW + 5'(gi / 2), COLUMN + 3'(gi % 2)};

            assign raw_all[gi] = {short_i[6*gi +: 6], open_i[6*gi +: 6],
                                  overheat_i[gi], overvoltage_i[gi], undervoltage_i[gi]};
            assign sample_en[gi] = (state_reg == S_SAMPLE) && (ch_idx_reg == 2'(gi));
            assign hit_vec[gi]   = rd_req && (rd_id == CH_ID);

            fault_debounce #(
                .DEB_N(DEB_N)
            ) u_deb (
                .clk       (sys_clk),
                .rst_n     (sys_resetb),
                .sample_en (sample_en[gi]),
                .raw       (raw_all[gi]),
                .clr       (hit_vec[gi]),
                .sticky    (sticky_all[gi])
`ifdef FAULT_IRQ_EN
                ,
                .rise      (rise_all[gi])
`endif
            );
        end
    endgenerate

    // ------------------------------------------------------------ read path
    logic [15:0] frames_next;
    logic        hit_next;
    logic        err_next;

    always_comb begin
        frames_next = 16'hFFFF;
        hit_next    = 1'b0;
        err_next    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_vec[c]) begin
                hit_next    = 1'b1;
                frames_next = build_frames(sticky_all[c]);
            end
            err_next = err_next | (|sticky_all[c]);
        end
    end

    logic       rd_ack_reg;
    logic       rd_hit_reg;
    logic [7:0] frame0_reg;
    logic [7:0] frame1_reg;
    logic       err_reg;

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            rd_ack_reg <= 1'b0;
            rd_hit_reg <= 1'b0;
            frame0_reg <= 8'hFF;
            frame1_reg <= 8'hFF;
            err_reg    <= 1'b0;
        end else begin
            rd_ack_reg <= rd_req;
            rd_hit_reg <= hit_next;
            if (rd_req) begin
                frame0_reg <= frames_next[15:8];
                frame1_reg <= frames_next[7:0];
            end
            err_reg <= err_next;
        end
    end

    assign rd_ack       = rd_ack_reg;
    assign rd_hit       = rd_hit_reg;
    assign frame0_o     = frame0_reg;
    assign frame1_o     = frame1_reg;
    assign error_flag_o = err_reg;
    assign scan_ch_o    = scan_ch_reg;

`ifdef FAULT_IRQ_EN
    // ------------------------------------------------------------------ irq
    logic irq_next;
    logic irq_reg;

    always_comb begin
        irq_next = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            irq_next = irq_next | ((|rise_all[c]) & ~irq_mask_i[c]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_next;
        end
    end

    assign irq_o = irq_reg;
`endif

endmodule
